// File: rtl/axil_master.sv
// axil_master: single-outstanding AXI-Lite initiator driven by a simple cmd/rsp interface.
// Define AXIL_MASTER_STATS_EN to add response counters (stat_wr_count, stat_rd_count, stat_err_count).
module axil_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
`ifdef AXIL_MASTER_STATS_EN
  ,
  output logic [31:0]           stat_wr_count,
  output logic [31:0]           stat_rd_count,
  output logic [15:0]           stat_err_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_WR_B = 3'd2,
    ST_RD_A = 3'd3,
    ST_RD_R = 3'd4,
    ST_RSP  = 3'd5
  } state_t;

  state_t state_r;

  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;

  // Transaction sequencer; every handshake output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_rdata      <= {DATA_WIDTH{1'b0}};
      rsp_resp       <= 2'b00;
      m_axil_awaddr  <= {ADDR_WIDTH{1'b0}};
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= {DATA_WIDTH{1'b0}};
      m_axil_wstrb   <= {STRB_WIDTH{1'b0}};
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_araddr  <= {ADDR_WIDTH{1'b0}};
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m_axil_awaddr  <= cmd_addr;
              m_axil_wdata   <= cmd_wdata;
              m_axil_wstrb   <= cmd_wstrb;
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              state_r        <= ST_WR;
            end else begin
              m_axil_araddr  <= cmd_addr;
              m_axil_arvalid <= 1'b1;
              state_r        <= ST_RD_A;
            end
          end
        end
        ST_WR: begin
          // AW and W retire independently; leave once neither is still pending.
          if (m_axil_awready) begin
            m_axil_awvalid <= 1'b0;
          end
          if (m_axil_wready) begin
            m_axil_wvalid <= 1'b0;
          end
          if ((!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)) begin
            m_axil_bready <= 1'b1;
            state_r       <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            rsp_resp      <= m_axil_bresp;
            rsp_rdata     <= {DATA_WIDTH{1'b0}};
            rsp_write     <= 1'b1;
            rsp_valid     <= 1'b1;
            state_r       <= ST_RSP;
          end
        end
        ST_RD_A: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state_r        <= ST_RD_R;
          end
        end
        ST_RD_R: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            rsp_rdata     <= m_axil_rdata;
            rsp_resp      <= m_axil_rresp;
            rsp_write     <= 1'b0;
            rsp_valid     <= 1'b1;
            state_r       <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          cmd_ready      <= 1'b1;
          rsp_valid      <= 1'b0;
          m_axil_awvalid <= 1'b0;
          m_axil_wvalid  <= 1'b0;
          m_axil_bready  <= 1'b0;
          m_axil_arvalid <= 1'b0;
          m_axil_rready  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIL_MASTER_STATS_EN
  // Completed-response counters, bumped on the response handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_wr_count  <= 32'd0;
      stat_rd_count  <= 32'd0;
      stat_err_count <= 16'd0;
    end else if (rsp_valid && rsp_ready) begin
      if (rsp_write) begin
        stat_wr_count <= stat_wr_count + 32'd1;
      end else begin
        stat_rd_count <= stat_rd_count + 32'd1;
      end
      if (rsp_resp != 2'b00) begin
        stat_err_count <= stat_err_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axil_master.sv
// tb_axil_master: drives axil_master against a behavioural AXI-Lite RAM slave with programmable wait states.
// Expected data comes from a byte-array memory model; expected latency from the zero-wait base plus wait states.
`timescale 1ns/1ps
module tb_axil_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [4:0]  m_axil_awaddr, m_axil_araddr;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [31:0] m_axil_wdata, m_axil_rdata;
  logic [3:0]  m_axil_wstrb;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;
`ifdef AXIL_MASTER_STATS_EN
  logic [31:0] stat_wr_count, stat_rd_count;
  logic [15:0] stat_err_count;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // slave configuration and observation counters
  int aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic [1:0] next_resp;
  int aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_hi, w_hi;
  int proto_err = 0;
  logic [7:0] ref_bytes [32];

  always #5 clk = ~clk;

  axil_master #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
`ifdef AXIL_MASTER_STATS_EN
    , .stat_wr_count(stat_wr_count), .stat_rd_count(stat_rd_count), .stat_err_count(stat_err_count)
`endif
  );

  // Behavioural AXI-Lite RAM slave; decides readies/valids on the falling edge.
  initial begin : slave
    logic [31:0] slv_mem [8];
    logic [4:0]  slv_awaddr, slv_araddr, prev_awaddr, prev_araddr;
    logic [31:0] slv_wdata, prev_wdata;
    logic [3:0]  slv_wstrb;
    bit aw_fire, aw_have, w_fire, w_have, b_fire, ar_fire, ar_have, r_fire;
    bit prev_awv, prev_wv, prev_arv;
    for (int i = 0; i < 8; i++) slv_mem[i] = 32'h0;
    m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
    m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; m_axil_rdata = 32'h0; m_axil_rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        {aw_fire, aw_have, w_fire, w_have, b_fire, ar_fire, ar_have, r_fire} = 8'h00;
        {prev_awv, prev_wv, prev_arv} = 3'b000;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0;
        m_axil_arready = 1'b0; m_axil_rvalid = 1'b0;
      end else begin
        if (aw_fire) begin aw_fire = 1'b0; aw_have = 1'b1; end
        if (w_fire)  begin w_fire = 1'b0;  w_have = 1'b1;  end
        if (b_fire)  begin b_fire = 1'b0;  m_axil_bvalid = 1'b0; end
        if (ar_fire) begin ar_fire = 1'b0; ar_have = 1'b1; end
        if (r_fire)  begin r_fire = 1'b0;  m_axil_rvalid = 1'b0; end
        // a valid still high after its own handshake, or payload moving while valid, is a violation
        if ((aw_have && m_axil_awvalid) || (w_have && m_axil_wvalid) || (ar_have && m_axil_arvalid)) proto_err++;
        if ((m_axil_awvalid && prev_awv && m_axil_awaddr !== prev_awaddr) ||
            (m_axil_wvalid && prev_wv && m_axil_wdata !== prev_wdata) ||
            (m_axil_arvalid && prev_arv && m_axil_araddr !== prev_araddr)) proto_err++;
        prev_awv = m_axil_awvalid; prev_awaddr = m_axil_awaddr;
        prev_wv = m_axil_wvalid; prev_wdata = m_axil_wdata;
        prev_arv = m_axil_arvalid; prev_araddr = m_axil_araddr;
        if (m_axil_awvalid) aw_hi++;
        if (m_axil_wvalid) w_hi++;

        m_axil_awready = 1'b0;
        if (m_axil_awvalid && !aw_have && !aw_fire) begin
          if (aw_wait > 0) aw_wait--;
          else begin m_axil_awready = 1'b1; aw_fire = 1'b1; aw_hs++; slv_awaddr = m_axil_awaddr; end
        end
        m_axil_wready = 1'b0;
        if (m_axil_wvalid && !w_have && !w_fire) begin
          if (w_wait > 0) w_wait--;
          else begin
            m_axil_wready = 1'b1; w_fire = 1'b1; w_hs++;
            slv_wdata = m_axil_wdata; slv_wstrb = m_axil_wstrb;
          end
        end
        if (aw_have && w_have && !m_axil_bvalid && !b_fire) begin
          if (b_wait > 0) b_wait--;
          else begin
            for (int i = 0; i < 4; i++)
              if (slv_wstrb[i]) slv_mem[slv_awaddr[4:2]][8*i +: 8] = slv_wdata[8*i +: 8];
            m_axil_bvalid = 1'b1; m_axil_bresp = next_resp;
          end
        end
        if (m_axil_bvalid && !b_fire && m_axil_bready) begin
          b_fire = 1'b1; b_hs++; aw_have = 1'b0; w_have = 1'b0;
        end

        m_axil_arready = 1'b0;
        if (m_axil_arvalid && !ar_have && !ar_fire) begin
          if (ar_wait > 0) ar_wait--;
          else begin m_axil_arready = 1'b1; ar_fire = 1'b1; ar_hs++; slv_araddr = m_axil_araddr; end
        end
        if (ar_have && !m_axil_rvalid && !r_fire) begin
          if (r_wait > 0) r_wait--;
          else begin
            m_axil_rvalid = 1'b1; m_axil_rdata = slv_mem[slv_araddr[4:2]]; m_axil_rresp = next_resp;
          end
        end
        if (m_axil_rvalid && !r_fire && m_axil_rready) begin
          r_fire = 1'b1; r_hs++; ar_have = 1'b0;
        end
      end
    end
  end

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    int b;
    b = (int'(a) / 4) * 4;
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  function automatic void ref_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int b;
    b = (int'(a) / 4) * 4;
    for (int i = 0; i < 4; i++)
      if (s[i]) ref_bytes[b+i] = d[8*i +: 8];
  endfunction

  // Issues one command, waits for its response, holds rsp_ready low for 'hold' cycles, then accepts it.
  task automatic do_cmd(input bit wr, input logic [4:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                        input logic [1:0] resp, input int hold,
                        input int awd, input int wdd, input int bd, input int ard, input int rdd,
                        output logic [31:0] rd, output logic [1:0] rs, output logic rw, output int lat);
    int guard;
    @(negedge clk);
    aw_wait = awd; w_wait = wdd; b_wait = bd; ar_wait = ard; r_wait = rdd; next_resp = resp;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; aw_hi = 0; w_hi = 0;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1'b1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_accept: cmd_ready=%b want 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    n_checks++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rsp_timeout: rsp_valid=%b want 1", rsp_valid); end
    rd = rsp_rdata; rs = rsp_resp; rw = rsp_write;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_write} !== {1'b1, 1'b0, rd, rs, rw}) begin
        n_fail++;
        $display("FAIL rsp_hold: valid=%b cmd_ready=%b rdata=%h resp=%b write=%b want 1 0 %h %b %b",
                 rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_write, rd, rs, rw);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rsp_release: rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_ready, m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready, rsp_valid} !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_ctrl: cmd_ready=%b aw=%b w=%b b=%b ar=%b r=%b rsp=%b want 1 0 0 0 0 0 0",
                         cmd_ready, m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready, rsp_valid);
    end
    n_checks++;
    if ({m_axil_awaddr, m_axil_araddr, m_axil_wdata, m_axil_wstrb, rsp_rdata, rsp_resp, rsp_write} !== 81'd0) begin
      n_fail++; $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h wstrb=%h rdata=%h resp=%b write=%b want all 0",
                         m_axil_awaddr, m_axil_araddr, m_axil_wdata, m_axil_wstrb, rsp_rdata, rsp_resp, rsp_write);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cmd_ready, m_axil_awprot, m_axil_arprot} !== 7'b1000000) begin
      n_fail++; $display("FAIL post_reset: cmd_ready=%b awprot=%b arprot=%b want 1 000 000", cmd_ready, m_axil_awprot, m_axil_arprot);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic [1:0] rs; logic rw; int lat;
    do_cmd(1'b1, 5'h04, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0, rd, rs, rw, lat);
    ref_write(5'h04, 32'hDEADBEEF, 4'hF);
    n_checks++;
    if ({rd, rs, rw} !== {32'h0, 2'b00, 1'b1} || lat !== 3) begin
      n_fail++; $display("FAIL wr_rsp: rdata=%h resp=%b write=%b lat=%0d want 00000000 00 1 3", rd, rs, rw, lat);
    end
    do_cmd(1'b0, 5'h04, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, rd, rs, rw, lat);
    n_checks++;
    if ({rd, rs, rw} !== {ref_read(5'h04), 2'b00, 1'b0} || lat !== 3) begin
      n_fail++; $display("FAIL rd_rsp: rdata=%h resp=%b write=%b lat=%0d want %h 00 0 3", rd, rs, rw, lat, ref_read(5'h04));
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd; logic [1:0] rs; logic rw; int lat;
    do_cmd(1'b1, 5'h04, 32'h000000AA, 4'b0001, 2'b00, 0, 0, 0, 0, 0, 0, rd, rs, rw, lat);
    ref_write(5'h04, 32'h000000AA, 4'b0001);
    do_cmd(1'b0, 5'h04, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, rd, rs, rw, lat);
    n_checks++;
    if (rd !== ref_read(5'h04)) begin
      n_fail++; $display("FAIL byte_write: rdata=%h want %h", rd, ref_read(5'h04));
    end
  endtask

  task automatic test_split_handshake();
    logic [31:0] rd; logic [1:0] rs; logic rw; int lat;
    // AW stalled 3 cycles, W immediate
    do_cmd(1'b1, 5'h0C, 32'h11223344, 4'hF, 2'b00, 0, 3, 0, 0, 0, 0, rd, rs, rw, lat);
    ref_write(5'h0C, 32'h11223344, 4'hF);
    n_checks++;
    if (aw_hi !== 4 || w_hi !== 1 || b_hs !== 1 || lat !== 6 || proto_err !== 0) begin
      n_fail++; $display("FAIL split_aw_late: aw_hi=%0d w_hi=%0d b_hs=%0d lat=%0d proto=%0d want 4 1 1 6 0",
                         aw_hi, w_hi, b_hs, lat, proto_err);
    end
    // W stalled 3 cycles, AW immediate
    do_cmd(1'b1, 5'h10, 32'h55667788, 4'hF, 2'b00, 0, 0, 3, 0, 0, 0, rd, rs, rw, lat);
    ref_write(5'h10, 32'h55667788, 4'hF);
    n_checks++;
    if (aw_hi !== 1 || w_hi !== 4 || b_hs !== 1 || lat !== 6 || proto_err !== 0) begin
      n_fail++; $display("FAIL split_w_late: aw_hi=%0d w_hi=%0d b_hs=%0d lat=%0d proto=%0d want 1 4 1 6 0",
                         aw_hi, w_hi, b_hs, lat, proto_err);
    end
    do_cmd(1'b0, 5'h0C, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, rd, rs, rw, lat);
    n_checks++;
    if (rd !== ref_read(5'h0C)) begin
      n_fail++; $display("FAIL split_readback: rdata=%h want %h", rd, ref_read(5'h0C));
    end
  endtask

  task automatic test_rsp_hold();
    logic [31:0] rd; logic [1:0] rs; logic rw; int lat;
    do_cmd(1'b0, 5'h10, 32'h0, 4'h0, 2'b00, 5, 0, 0, 0, 0, 0, rd, rs, rw, lat);
    n_checks++;
    if ({rd, rs, rw} !== {ref_read(5'h10), 2'b00, 1'b0} || r_hs !== 1) begin
      n_fail++; $display("FAIL rsp_hold_data: rdata=%h resp=%b write=%b r_hs=%0d want %h 00 0 1", rd, rs, rw, r_hs, ref_read(5'h10));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic [1:0] rs; logic rw; int lat; int guard;
    @(negedge clk);
    aw_wait = 6; w_wait = 6; b_wait = 0; next_resp = 2'b00; b_hs = 0;
    cmd_write = 1'b1; cmd_addr = 5'h08; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (m_axil_awvalid !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    n_checks++;
    if (m_axil_awvalid !== 1'b1) begin n_fail++; $display("FAIL mid_setup: awvalid=%b want 1", m_axil_awvalid); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({m_axil_awvalid, m_axil_wvalid, rsp_valid, cmd_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL mid_reset: aw=%b w=%b rsp=%b cmd_ready=%b want 0 0 0 1",
                         m_axil_awvalid, m_axil_wvalid, rsp_valid, cmd_ready);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    n_checks++;
    if (b_hs !== 0) begin n_fail++; $display("FAIL mid_no_b: b_hs=%0d want 0", b_hs); end
    do_cmd(1'b0, 5'h08, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, rd, rs, rw, lat);
    n_checks++;
    if ({rd, rs, rw} !== {ref_read(5'h08), 2'b00, 1'b0} || lat !== 3) begin
      n_fail++; $display("FAIL mid_read: rdata=%h resp=%b write=%b lat=%0d want %h 00 0 3", rd, rs, rw, lat, ref_read(5'h08));
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, exp_rd; logic [1:0] rs, resp; logic rw; logic [4:0] addr; logic [3:0] ws;
    int lat, exp_lat, awd, wdd, bd, ard, rdd, hold; bit wr;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      addr = 5'(4 * $urandom_range(0, 7));
      wd = $urandom; ws = 4'($urandom_range(0, 15)); resp = 2'($urandom_range(0, 3));
      awd = $urandom_range(0, 3); wdd = $urandom_range(0, 3); bd = $urandom_range(0, 3);
      ard = $urandom_range(0, 3); rdd = $urandom_range(0, 3); hold = $urandom_range(0, 2);
      do_cmd(wr, addr, wd, ws, resp, hold, awd, wdd, bd, ard, rdd, rd, rs, rw, lat);
      if (wr) begin
        ref_write(addr, wd, ws);
        exp_rd = 32'h0;
        exp_lat = 3 + ((awd > wdd) ? awd : wdd) + bd;
      end else begin
        exp_rd = ref_read(addr);
        exp_lat = 3 + ard + rdd;
      end
      n_checks++;
      if ({rd, rs, rw} !== {exp_rd, resp, wr}) begin
        n_fail++; $display("FAIL rand_rsp[%0d]: rdata=%h resp=%b write=%b want %h %b %b", n, rd, rs, rw, exp_rd, resp, wr);
      end
      n_checks++;
      if (lat !== exp_lat || (wr ? b_hs : r_hs) !== 1 || proto_err !== 0) begin
        n_fail++; $display("FAIL rand_timing[%0d]: lat=%0d hs=%0d proto=%0d want %0d 1 0",
                           n, lat, (wr ? b_hs : r_hs), proto_err, exp_lat);
      end
    end
  endtask

`ifdef AXIL_MASTER_STATS_EN
  task automatic test_stats();
    logic [31:0] rd; logic [1:0] rs; logic rw; int lat;
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      do_cmd(1'b1, 5'(4 * i), 32'hA5A50000 + 32'(i), 4'hF, 2'b00, 0, 0, 0, 0, 0, 0, rd, rs, rw, lat);
      ref_write(5'(4 * i), 32'hA5A50000 + 32'(i), 4'hF);
    end
    do_cmd(1'b0, 5'h00, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, rd, rs, rw, lat);
    do_cmd(1'b0, 5'h04, 32'h0, 4'h0, 2'b10, 0, 0, 0, 0, 0, 0, rd, rs, rw, lat);
    n_checks++;
    if (rs !== 2'b10) begin n_fail++; $display("FAIL stats_slverr: resp=%b want 10", rs); end
    n_checks++;
    if (stat_wr_count !== 32'd3 || stat_rd_count !== 32'd2 || stat_err_count !== 16'd1) begin
      n_fail++; $display("FAIL stats_counts: wr=%0d rd=%0d err=%0d want 3 2 1", stat_wr_count, stat_rd_count, stat_err_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 5'h0; cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0; rsp_ready = 1'b0; next_resp = 2'b00;
    for (int i = 0; i < 32; i++) ref_bytes[i] = 8'h00;
    test_reset();
    test_write_read();
    test_byte_write();
    test_split_handshake();
    test_rsp_hold();
    test_reset_mid();
    test_random();
`ifdef AXIL_MASTER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_master.md
Name: axil_master

Overview:
- AXI-Lite initiator: converts a simple single-command request/response interface into AXI-Lite read and write transactions.
- Drives the s_axil_* slave port of axil_ram, and any other AXI-Lite slave.
- One outstanding transaction at a time.
- Used to drive the RAM from internal logic and benches instead of hand-toggled regs.

Parameters:
- DATA_WIDTH, 32, AXI-Lite data width in bits; multiple of 8.
- ADDR_WIDTH, 5, AXI-Lite byte-address width.
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept; high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  STRB_WIDTH  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accept.
- rsp_write  out  1  echoes cmd_write of the completed command.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP from the slave.
- m_axil_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1;  m_axil_awready  in  1.
- m_axil_wdata/wstrb/wvalid  out  DATA_WIDTH/STRB_WIDTH/1;  m_axil_wready  in  1.
- m_axil_bresp  in  2;  m_axil_bvalid  in  1;  m_axil_bready  out  1.
- m_axil_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1;  m_axil_arready  in  1.
- m_axil_rdata  in  DATA_WIDTH;  m_axil_rresp  in  2;  m_axil_rvalid  in  1;  m_axil_rready  out  1.

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE.
  - All valid and ready outputs are 0, except cmd_ready = 1.
  - rsp_rdata, rsp_resp, rsp_write, and all address/data/strb outputs are 0.
  - Asserting reset mid-transaction drops all valids immediately; no completion is reported.
- awprot and arprot are constant 3'b000.
- All outputs are registered; no combinational path from any input to any output.
- IDLE: cmd_ready = 1. On cmd_valid & cmd_ready, capture addr/wdata/wstrb/write and go to WR if write, RD_A if read.
- WR:
  - awvalid and wvalid both rise the cycle after acceptance.
  - Each drops independently on its own handshake (valid & ready); payload is held stable until then.
  - AW and W may complete in the same cycle or in either order.
  - When both are done, go to WR_B with bready = 1.
- WR_B: on bvalid, capture bresp into rsp_resp, set rsp_rdata = 0, rsp_write = 1, bready = 0, go to RSP.
- RD_A: arvalid = 1 with araddr held stable; on arready, arvalid = 0, rready = 1, go to RD_R.
- RD_R: on rvalid, capture rdata and rresp, rready = 0, rsp_write = 0, go to RSP.
- RSP:
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE (cmd_ready = 1 the next cycle).
  - No new command is accepted while a response is pending.
- Minimum latency (slave ready with zero wait), command accepted in cycle N:
  - Write: aw/wvalid at N+1, bvalid at N+2, rsp_valid at N+3.
  - Read: arvalid at N+1, rvalid at N+2, rsp_valid at N+3.
- Throughput: at most one command per 4 cycles.
- Non-OKAY responses (SLVERR/DECERR) are passed through unchanged; no retry.
- Unexpected bvalid or rvalid outside WR_B or RD_R is ignored, because the matching ready is low.

Optional Feature:
- Macro: AXIL_MASTER_STATS_EN.
- Enabled:
  - Adds outputs stat_wr_count[31:0], stat_rd_count[31:0], stat_err_count[15:0]. All reset to 0.
  - Counts increment on the response handshake (rsp_valid & rsp_ready): write count for writes, read count for reads, error count when rsp_resp != 2'b00.
  - Counters wrap modulo 2^width.
- Disabled: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Write 0xDEADBEEF to addr 0x04 (wstrb 4'hF) into axil_ram, then read addr 0x04 -> write rsp_resp = 0; read rsp_rdata = 0xDEADBEEF, rsp_write = 0, rsp_resp = 0.
- Byte write 0x000000AA to addr 0x04 with wstrb 4'b0001, then read -> 0xDEADBEAA.
- Stub slave delays awready 3 cycles and wready 0 cycles (then the reverse) -> wvalid drops after its own handshake, awvalid stays high until its own, exactly one B handshake, one response.
- Hold rsp_ready = 0 for 5 cycles after rsp_valid -> rsp_* stable, cmd_ready = 0 throughout, cmd_ready = 1 the cycle after the handshake.
- Assert rst low while awvalid = 1 -> awvalid, wvalid, rsp_valid = 0 immediately, cmd_ready = 1; a following read of 0x08 completes normally.
- With AXIL_MASTER_STATS_EN, run 3 writes and 2 reads, one returning SLVERR (2'b10) -> wr = 3, rd = 2, err = 1.
